// File: rtl/unified_mem_pkg.sv
// ----------------------------------------------------------------------------
// unified_mem_pkg
// Shared types and constants for the tagged unified instruction/data memory:
// bus command and access-size encodings, the transaction tag type, a 64-bit
// line view with byte/half/word lanes, and the pending-load queue entry.
// No ports (package).
// ----------------------------------------------------------------------------
package unified_mem_pkg;

    localparam int unsigned XLEN              = 32;
    localparam int unsigned MEM_SIZE_IN_BYTES = 65536;
    localparam int unsigned MEM_64BIT_LINES   = MEM_SIZE_IN_BYTES / 8;
    localparam int unsigned MEM_LATENCY       = 10;
    localparam int unsigned NUM_TAGS          = 15;
    localparam int unsigned TAG_W             = 4;
    localparam int unsigned CYC_W             = 32;

    typedef enum logic [1:0] {
        BUS_NONE  = 2'd0,
        BUS_LOAD  = 2'd1,
        BUS_STORE = 2'd2
    } BUS_COMMAND;

    typedef enum logic [1:0] {
        BYTE   = 2'd0,
        HALF   = 2'd1,
        WORD   = 2'd2,
        DOUBLE = 2'd3
    } MEM_SIZE;

    typedef logic [TAG_W-1:0] MEM_TAG;

    // One 64-bit line viewed as whole, words, halves or bytes (lane 0 = LSBs).
    typedef union packed {
        logic [63:0]      dword;
        logic [1:0][31:0] words;
        logic [3:0][15:0] halves;
        logic [7:0][7:0]  bytes;
    } EXAMPLE_CACHE_BLOCK;

    // Pending load: tag, snapshotted line and the cycle it becomes due.
    typedef struct packed {
        MEM_TAG           tag;
        logic [63:0]      data;
        logic [CYC_W-1:0] due;
    } pend_load_t;

endpackage

// File: rtl/unified_mem_tag_pool.sv
// ----------------------------------------------------------------------------
// mem_tag_pool
// Free-tag bitmap for tags 1..NUM_TAGS with a lowest-free priority encoder.
// Ports:
//   clk, reset        clock, synchronous active-high reset (all tags free)
//   i_alloc/i_alloc_tag  mark a tag busy at this edge
//   i_free/i_free_tag    mark a tag free at this edge (usable from next edge)
//   o_free_tag_c      lowest free tag, 0 when none (combinational)
//   o_any_free_c      at least one tag is free (combinational)
// ----------------------------------------------------------------------------
module mem_tag_pool
    import unified_mem_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             i_alloc,
    input  logic [TAG_W-1:0] i_alloc_tag,
    input  logic             i_free,
    input  logic [TAG_W-1:0] i_free_tag,
    output logic [TAG_W-1:0] o_free_tag_c,
    output logic             o_any_free_c
);

    logic [NUM_TAGS-1:0] r_busy;
    logic [NUM_TAGS-1:0] w_busy_nxt;
    logic [TAG_W-1:0]    w_alloc_idx;
    logic [TAG_W-1:0]    w_free_idx;

    // Tag n lives in bitmap bit n-1.
    assign w_alloc_idx = TAG_W'(i_alloc_tag - TAG_W'(1));
    assign w_free_idx  = TAG_W'(i_free_tag  - TAG_W'(1));

    // Lowest free tag: scan downward so the smallest index wins.
    always_comb begin
        o_free_tag_c = '0;
        o_any_free_c = 1'b0;
        for (int i = NUM_TAGS - 1; i >= 0; i--) begin
            if (!r_busy[i]) begin
                o_free_tag_c = TAG_W'(i + 1);
                o_any_free_c = 1'b1;
            end
        end
    end

    // Next bitmap; alloc and free never target the same tag in one cycle.
    always_comb begin
        w_busy_nxt = r_busy;
        if (i_free) begin
            w_busy_nxt[w_free_idx] = 1'b0;
        end
        if (i_alloc) begin
            w_busy_nxt[w_alloc_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_busy <= '0;
        end else begin
            r_busy <= w_busy_nxt;
        end
    end

endmodule

// File: rtl/unified_mem.sv
// ----------------------------------------------------------------------------
// unified_mem
// Behavioural tagged fixed-latency unified instruction/data memory. Accepts
// one load/store per cycle, answers with a tag the next cycle, and returns
// load lines MEM_LATENCY cycles after the response, oldest first, one per
// cycle. The backing array unified_memory is visible hierarchically.
// Optional feature macro: SIZED_ACCESS_EN (adds proc2mem_size, enables
// byte/half/word store merging and per-size alignment checks).
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   proc2mem_command    BUS_NONE/LOAD/STORE (3 behaves as NONE)
//   proc2mem_addr       byte address
//   proc2mem_data       store data
//   proc2mem_size       access size (SIZED_ACCESS_EN only)
//   mem2proc_response   tag granted to previous cycle's request, 0 = rejected
//   mem2proc_data       returned load line (0 when no completion)
//   mem2proc_tag        tag of completing load, 0 = none
// ----------------------------------------------------------------------------
module unified_mem #(
    parameter int unsigned XLEN              = unified_mem_pkg::XLEN,
    parameter int unsigned MEM_SIZE_IN_BYTES = unified_mem_pkg::MEM_SIZE_IN_BYTES,
    parameter int unsigned MEM_LATENCY       = unified_mem_pkg::MEM_LATENCY
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [1:0]      proc2mem_command,
    input  logic [XLEN-1:0] proc2mem_addr,
    input  logic [63:0]     proc2mem_data,
`ifdef SIZED_ACCESS_EN
    input  logic [1:0]      proc2mem_size,
`endif
    output logic [3:0]      mem2proc_response,
    output logic [63:0]     mem2proc_data,
    output logic [3:0]      mem2proc_tag
);

    import unified_mem_pkg::*;

    localparam int unsigned LINES  = MEM_SIZE_IN_BYTES / 8;
    localparam int unsigned LINE_W = $clog2(LINES);
    localparam int unsigned QDEPTH = 16;
    localparam int unsigned QPTR_W = 4;
    localparam int unsigned QCNT_W = 5;

    logic [63:0] unified_memory [LINES];

    pend_load_t        r_q [QDEPTH];
    logic [QPTR_W-1:0] r_wptr;
    logic [QPTR_W-1:0] r_rptr;
    logic [QCNT_W-1:0] r_count;
    logic [CYC_W-1:0]  r_cycle;
    MEM_TAG            r_response;
    MEM_TAG            r_tag;
    logic [63:0]       r_data;

    logic              w_is_load;
    logic              w_is_store;
    logic              w_in_range;
    logic              w_aligned;
    logic              w_accept;
    logic              w_push;
    logic              w_pop;
    logic [LINE_W-1:0] w_line;
    logic [63:0]       w_rd_line;
    logic [63:0]       w_wr_line;
    MEM_TAG            w_free_tag;
    logic              w_any_free;
    pend_load_t        w_head;
    logic [CYC_W-1:0]  w_head_slack;

    // Request decode and acceptance.
    assign w_is_load  = (proc2mem_command == BUS_LOAD);
    assign w_is_store = (proc2mem_command == BUS_STORE);
    assign w_in_range = (proc2mem_addr < XLEN'(MEM_SIZE_IN_BYTES));
    assign w_accept   = !reset && (w_is_load || w_is_store) && w_in_range
                        && w_aligned && w_any_free;
    assign w_push     = w_accept && w_is_load;

    assign w_line    = proc2mem_addr[LINE_W+2:3];
    assign w_rd_line = unified_memory[w_line];

`ifdef SIZED_ACCESS_EN
    EXAMPLE_CACHE_BLOCK w_blk;

    // Alignment check and lane merge of store data into the current line.
    always_comb begin
        w_blk.dword = w_rd_line;
        w_aligned   = 1'b1;
        case (MEM_SIZE'(proc2mem_size))
            BYTE: begin
                w_blk.bytes[proc2mem_addr[2:0]] = proc2mem_data[7:0];
            end
            HALF: begin
                w_aligned = !proc2mem_addr[0];
                w_blk.halves[proc2mem_addr[2:1]] = proc2mem_data[15:0];
            end
            WORD: begin
                w_aligned = (proc2mem_addr[1:0] == 2'b00);
                w_blk.words[proc2mem_addr[2]] = proc2mem_data[31:0];
            end
            DOUBLE: begin
                w_aligned   = (proc2mem_addr[2:0] == 3'b000);
                w_blk.dword = proc2mem_data;
            end
        endcase
    end

    assign w_wr_line = w_blk.dword;
`else
    // Every access is a full line; the low address bits select nothing.
    assign w_aligned = 1'b1;
    assign w_wr_line = proc2mem_data;
`endif

    mem_tag_pool u_tag_pool (
        .clk          (clk),
        .reset        (reset),
        .i_alloc      (w_push),
        .i_alloc_tag  (w_free_tag),
        .i_free       (w_pop),
        .i_free_tag   (w_head.tag),
        .o_free_tag_c (w_free_tag),
        .o_any_free_c (w_any_free)
    );

    // Head is due once the free-running cycle count reaches its due stamp;
    // the wrap-safe sign test lets a slipped head still issue.
    assign w_head       = r_q[r_rptr];
    assign w_head_slack = r_cycle - w_head.due;
    assign w_pop        = (r_count != '0) && !w_head_slack[CYC_W-1];

    // Backing store: never reset, so a program image survives reset.
    always_ff @(posedge clk) begin
        if (w_accept && w_is_store) begin
            unified_memory[w_line] <= w_wr_line;
        end
    end

    // Pending-load payload storage; validity is tracked by the pointers.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_q[r_wptr] <= '{tag:  w_free_tag,
                             data: w_rd_line,
                             due:  r_cycle + CYC_W'(MEM_LATENCY)};
        end
    end

    // Queue control, cycle count and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
            r_cycle    <= '0;
            r_response <= '0;
            r_tag      <= '0;
            r_data     <= '0;
        end else begin
            r_cycle    <= r_cycle + CYC_W'(1);
            r_response <= w_accept ? w_free_tag : MEM_TAG'(0);
            if (w_push) begin
                r_wptr <= r_wptr + QPTR_W'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + QPTR_W'(1);
                r_tag  <= w_head.tag;
                r_data <= w_head.data;
            end else begin
                r_tag  <= '0;
                r_data <= '0;
            end
            r_count <= r_count + QCNT_W'(w_push) - QCNT_W'(w_pop);
        end
    end

    assign mem2proc_response = r_response;
    assign mem2proc_tag      = r_tag;
    assign mem2proc_data     = r_data;

endmodule

// File: tb/tb_unified_mem.sv
// ----------------------------------------------------------------------------
// tb_unified_mem
// Scoreboard bench for unified_mem. The driver pushes the expected response
// and, for accepted loads, the expected completion; a negedge monitor pops
// and compares whatever the DUT presents. Runs with a longer latency so
// fifteen back-to-back loads can all be outstanding at once.
// ----------------------------------------------------------------------------
module tb_unified_mem;

    localparam int LAT = 20;

    localparam logic [1:0] C_NONE  = 2'd0;
    localparam logic [1:0] C_LOAD  = 2'd1;
    localparam logic [1:0] C_STORE = 2'd2;
    localparam logic [1:0] S_BYTE  = 2'd0;
    localparam logic [1:0] S_HALF  = 2'd1;
    localparam logic [1:0] S_WORD  = 2'd2;
    localparam logic [1:0] S_DBL   = 2'd3;

`ifdef SIZED_ACCESS_EN
    localparam logic [3:0] T_MISALIGNED_LOAD = 4'd0;
    localparam logic [3:0] T_STORE_AFTER     = 4'd1;
`else
    localparam logic [3:0] T_MISALIGNED_LOAD = 4'd1;
    localparam logic [3:0] T_STORE_AFTER     = 4'd2;
`endif

    typedef struct {
        int         cyc;
        logic [3:0] val;
    } resp_exp_t;

    typedef struct {
        int          cyc;
        logic [3:0]  tag;
        logic [63:0] data;
    } cpl_exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  cmd;
    logic [31:0] addr;
    logic [63:0] wdata;
    logic [1:0]  size;
    logic [3:0]  mem2proc_response;
    logic [63:0] mem2proc_data;
    logic [3:0]  mem2proc_tag;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    resp_exp_t resp_q[$];
    cpl_exp_t  cpl_q[$];
    resp_exp_t rq;
    cpl_exp_t  cq;

    unified_mem #(.MEM_LATENCY(LAT)) dut (
        .clk               (clk),
        .reset             (reset),
        .proc2mem_command  (cmd),
        .proc2mem_addr     (addr),
        .proc2mem_data     (wdata),
`ifdef SIZED_ACCESS_EN
        .proc2mem_size     (size),
`endif
        .mem2proc_response (mem2proc_response),
        .mem2proc_data     (mem2proc_data),
        .mem2proc_tag      (mem2proc_tag)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at cycle %0d: actual=%h required=%h", nm, cyc, act, exp);
        end
    endtask

    // Monitor: compare responses and completions against the scoreboard.
    always @(negedge clk) begin
        if (resp_q.size() != 0 && resp_q[0].cyc == cyc) begin
            rq = resp_q.pop_front();
            chk("response", 64'(mem2proc_response), 64'(rq.val));
        end else begin
            chk("idle_response", 64'(mem2proc_response), 64'd0);
        end
        if (mem2proc_tag != 4'd0) begin
            if (cpl_q.size() == 0) begin
                chk("unexpected_completion_tag", 64'(mem2proc_tag), 64'd0);
            end else begin
                cq = cpl_q.pop_front();
                chk("completion_tag", 64'(mem2proc_tag), 64'(cq.tag));
                chk("completion_data", mem2proc_data, cq.data);
                chk("completion_cycle", 64'(cyc), 64'(cq.cyc));
            end
        end else begin
            chk("idle_data", mem2proc_data, 64'd0);
            if (cpl_q.size() != 0 && cpl_q[0].cyc <= cyc) begin
                cq = cpl_q.pop_front();
                chk("missing_completion_tag", 64'(mem2proc_tag), 64'(cq.tag));
            end
        end
    end

    task automatic req(input logic [1:0] c, input logic [31:0] a, input logic [63:0] d,
                       input logic [1:0] sz, input logic [3:0] exp_resp,
                       input logic [63:0] exp_data);
        @(negedge clk);
        cmd   = c;
        addr  = a;
        wdata = d;
        size  = sz;
        resp_q.push_back('{cyc + 1, exp_resp});
        if (c == C_LOAD && exp_resp != 4'd0) begin
            cpl_q.push_back('{cyc + 1 + LAT, exp_resp, exp_data});
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            cmd = C_NONE;
        end
    endtask

    // Reset discards outstanding loads, so their expectations go too.
    task automatic do_reset(input int n);
        @(negedge clk);
        #1;
        reset = 1'b1;
        cmd   = C_NONE;
        cpl_q.delete();
        repeat (n) @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1);
    end

    initial begin
        reset = 1'b1;
        cmd   = C_NONE;
        addr  = '0;
        wdata = '0;
        size  = S_DBL;
        repeat (4) @(negedge clk);
        chk("reset_response", 64'(mem2proc_response), 64'd0);
        chk("reset_tag", 64'(mem2proc_tag), 64'd0);
        chk("reset_data", mem2proc_data, 64'd0);
        reset = 1'b0;

        // Memory contents survive reset.
        req(C_STORE, 32'h0, 64'h0000_0000_0000_0013, S_DBL, 4'd1, 64'd0);
        do_reset(4);
        req(C_LOAD, 32'h0, 64'd0, S_DBL, 4'd1, 64'h0000_0000_0000_0013);
        idle(LAT + 4);

        // Store then load the same line; store tag is reused immediately.
        req(C_STORE, 32'h100, 64'hDEADBEEF_CAFEF00D, S_DBL, 4'd1, 64'd0);
        req(C_LOAD,  32'h100, 64'd0, S_DBL, 4'd1, 64'hDEADBEEF_CAFEF00D);
        idle(LAT + 4);

        // Range, alignment and command boundaries.
        req(C_LOAD,  32'h0001_0000, 64'd0, S_DBL, 4'd0, 64'd0);
        req(C_LOAD,  32'h0000_0107, 64'd0, S_DBL, T_MISALIGNED_LOAD, 64'hDEADBEEF_CAFEF00D);
        req(C_STORE, 32'h0000_FFF8, 64'h11223344_55667788, S_DBL, T_STORE_AFTER, 64'd0);
        req(C_LOAD,  32'h0000_FFF8, 64'd0, S_DBL, T_STORE_AFTER, 64'h11223344_55667788);
        req(2'd3,    32'h0000_0100, 64'd0, S_DBL, 4'd0, 64'd0);
        req(C_LOAD,  32'hFFFF_FFF8, 64'd0, S_DBL, 4'd0, 64'd0);
        idle(LAT + 4);

        // Fill all fifteen tags, overflow, then reuse tag 1 after it frees.
        for (int i = 0; i < 15; i++) begin
            req(C_LOAD, 32'h100, 64'd0, S_DBL, 4'(i + 1), 64'hDEADBEEF_CAFEF00D);
        end
        req(C_LOAD, 32'h100, 64'd0, S_DBL, 4'd0, 64'd0);
        idle(LAT - 16);
        req(C_LOAD, 32'h100, 64'd0, S_DBL, 4'd0, 64'd0);
        req(C_LOAD, 32'h100, 64'd0, S_DBL, 4'd1, 64'hDEADBEEF_CAFEF00D);
        idle(LAT + 20);

`ifdef SIZED_ACCESS_EN
        // Partial stores merge into the addressed lanes only.
        req(C_STORE, 32'h200, 64'd0, S_DBL, 4'd1, 64'd0);
        req(C_STORE, 32'h203, 64'h55555555_555555AB, S_BYTE, 4'd1, 64'd0);
        req(C_LOAD,  32'h200, 64'd0, S_DBL, 4'd1, 64'h00000000_AB000000);
        req(C_STORE, 32'h201, 64'h0000_0000_0000_BEEF, S_HALF, 4'd0, 64'd0);
        req(C_STORE, 32'h204, 64'hFFFFFFFF_12345678, S_WORD, 4'd2, 64'd0);
        req(C_LOAD,  32'h200, 64'd0, S_DBL, 4'd2, 64'h12345678_AB000000);
        req(C_LOAD,  32'h204, 64'd0, S_DBL, 4'd0, 64'd0);
        idle(LAT + 4);
`endif

        // Reset with loads outstanding: none may ever return.
        req(C_LOAD, 32'h100, 64'd0, S_DBL, 4'd1, 64'hDEADBEEF_CAFEF00D);
        req(C_LOAD, 32'h100, 64'd0, S_DBL, 4'd2, 64'hDEADBEEF_CAFEF00D);
        req(C_LOAD, 32'h100, 64'd0, S_DBL, 4'd3, 64'hDEADBEEF_CAFEF00D);
        idle(2);
        do_reset(4);
        req(C_LOAD, 32'h100, 64'd0, S_DBL, 4'd1, 64'hDEADBEEF_CAFEF00D);
        idle(LAT + 8);

        chk("pending_completions_left", 64'(cpl_q.size()), 64'd0);
        chk("pending_responses_left", 64'(resp_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
